// File: rtl/uart_axi_pkg.sv
// Shared constants and state encoding for the UART command parser.
package uart_axi_pkg;

  // Command bytes received from the host
  localparam logic [7:0] CMD_WR  = 8'h57;  // 'W'
  localparam logic [7:0] CMD_RD  = 8'h52;  // 'R'

  // Status bytes returned to the host
  localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR = 8'h45;  // 'E'
  localparam logic [7:0] RSP_TMO = 8'h54;  // 'T'
  localparam logic [7:0] RSP_UNK = 8'h3F;  // '?'

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_ADDR = 3'd1,
    ST_GET_DATA = 3'd2,
    ST_WR_REQ   = 3'd3,
    ST_WR_WAIT  = 3'd4,
    ST_RD_REQ   = 3'd5,
    ST_RD_WAIT  = 3'd6,
    ST_SEND     = 3'd7
  } state_t;

endpackage

// File: rtl/byte_serializer.sv
// Emits a status byte, optionally followed by a DATA_WIDTH word, MSB first
// over a valid/ready byte stream. One byte per cycle when the sink is ready.
module byte_serializer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [7:0]            status,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  with_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  done
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int SW = DATA_WIDTH + 8;
  localparam int CW = $clog2(NB + 2);

  logic [SW-1:0] shift_r;
  logic [CW-1:0] left_r;
  logic          valid_r;
  logic          fire_s;

  assign fire_s   = valid_r & tx_ready;
  // done marks the handshake of the final byte of the response
  assign done     = fire_s & (left_r == CW'(1));
  assign tx_data  = shift_r[SW-1 -: 8];
  assign tx_valid = valid_r;

  // Load a new response, or advance one byte after each accepted handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r <= '0;
      left_r  <= '0;
      valid_r <= 1'b0;
    end else if (load) begin
      shift_r <= {status, data};
      left_r  <= with_data ? CW'(NB + 1) : CW'(1);
      valid_r <= 1'b1;
    end else if (fire_s) begin
      shift_r <= {shift_r[SW-9:0], 8'h00};
      left_r  <= left_r - CW'(1);
      valid_r <= (left_r != CW'(1));
    end
  end

endmodule

// File: rtl/uart_axi_cmd_parser.sv
// Byte-stream command decoder: assembles 'W'/'R' commands from rx bytes,
// issues them on the mwr/mrd master ports and returns a status (plus read
// data) on the tx byte stream.
module uart_axi_cmd_parser
  import uart_axi_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  mwr_valid,
  output logic [ADDR_WIDTH-1:0] mwr_addr,
  output logic [DATA_WIDTH-1:0] mwr_data,
  input  logic                  mwr_ready,
  input  logic                  mwr_error,
  output logic                  mrd_addr_valid,
  output logic [ADDR_WIDTH-1:0] mrd_addr,
  input  logic                  mrd_addr_ready,
  input  logic [DATA_WIDTH-1:0] mrd_data,
  input  logic                  mrd_data_valid,
  output logic                  mrd_data_ready,
  input  logic                  mrd_error
);

  localparam int AB = ADDR_WIDTH / 8;
  localparam int DB = DATA_WIDTH / 8;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    ADDR_LAST = 8'(AB - 1);
  localparam logic [7:0]    DATA_LAST = 8'(DB - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  state_t                state_r;
  logic                  rx_ready_r;
  logic                  mwr_valid_r;
  logic                  mrd_addr_valid_r;
  logic                  mrd_data_ready_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic [7:0]            cnt_r;
  logic [TW-1:0]         tmo_r;
  logic                  is_read_r;
  logic                  err_r;
  logic                  wr_first_r;
  logic                  load_r;
  logic [7:0]            rsp_status_r;
  logic [DATA_WIDTH-1:0] rsp_data_r;
  logic                  rsp_with_data_r;

  logic                  rx_fire_s;
  logic                  tmo_hit_s;
  logic                  ser_done_s;

  assign rx_fire_s = rx_valid & rx_ready_r;
  // >= guards against a handshake landing on the final count and skipping past it
  assign tmo_hit_s = (tmo_r >= TMO_LAST);

  assign rx_ready       = rx_ready_r;
  assign mwr_valid      = mwr_valid_r;
  assign mwr_addr       = addr_r;
  assign mwr_data       = data_r;
  assign mrd_addr_valid = mrd_addr_valid_r;
  assign mrd_addr       = addr_r;
  assign mrd_data_ready = mrd_data_ready_r;

  // Command FSM: byte assembly, bus request/wait with timeout, response hand-off
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= ST_IDLE;
      rx_ready_r       <= 1'b1;
      mwr_valid_r      <= 1'b0;
      mrd_addr_valid_r <= 1'b0;
      mrd_data_ready_r <= 1'b0;
      addr_r           <= '0;
      data_r           <= '0;
      cnt_r            <= 8'd0;
      tmo_r            <= '0;
      is_read_r        <= 1'b0;
      err_r            <= 1'b0;
      wr_first_r       <= 1'b0;
      load_r           <= 1'b0;
      rsp_status_r     <= 8'h00;
      rsp_data_r       <= '0;
      rsp_with_data_r  <= 1'b0;
    end else begin
      load_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          cnt_r <= 8'd0;
          tmo_r <= '0;
          err_r <= 1'b0;
          if (rx_fire_s) begin
            if (rx_data == CMD_WR || rx_data == CMD_RD) begin
              is_read_r <= (rx_data == CMD_RD);
              state_r   <= ST_GET_ADDR;
            end else begin
              rx_ready_r      <= 1'b0;
              rsp_status_r    <= RSP_UNK;
              rsp_data_r      <= '0;
              rsp_with_data_r <= 1'b0;
              load_r          <= 1'b1;
              state_r         <= ST_SEND;
            end
          end
        end
        ST_GET_ADDR: begin
          if (rx_fire_s) begin
            addr_r <= (addr_r << 4'd8) | ADDR_WIDTH'(rx_data);
            tmo_r  <= '0;
            if (cnt_r == ADDR_LAST) begin
              cnt_r <= 8'd0;
              if (is_read_r) begin
                rx_ready_r       <= 1'b0;
                mrd_addr_valid_r <= 1'b1;
                state_r          <= ST_RD_REQ;
              end else begin
                state_r <= ST_GET_DATA;
              end
            end else begin
              cnt_r <= cnt_r + 8'd1;
            end
          end else if (tmo_hit_s) begin
            // partial command is discarded without any bus access
            cnt_r   <= 8'd0;
            tmo_r   <= '0;
            state_r <= ST_IDLE;
          end else begin
            tmo_r <= tmo_r + TW'(1);
          end
        end
        ST_GET_DATA: begin
          if (rx_fire_s) begin
            data_r <= (data_r << 4'd8) | DATA_WIDTH'(rx_data);
            tmo_r  <= '0;
            if (cnt_r == DATA_LAST) begin
              cnt_r       <= 8'd0;
              rx_ready_r  <= 1'b0;
              mwr_valid_r <= 1'b1;
              state_r     <= ST_WR_REQ;
            end else begin
              cnt_r <= cnt_r + 8'd1;
            end
          end else if (tmo_hit_s) begin
            cnt_r   <= 8'd0;
            tmo_r   <= '0;
            state_r <= ST_IDLE;
          end else begin
            tmo_r <= tmo_r + TW'(1);
          end
        end
        ST_WR_REQ: begin
          if (mwr_ready) begin
            mwr_valid_r <= 1'b0;
            wr_first_r  <= 1'b1;
            err_r       <= mwr_error;
            tmo_r       <= tmo_r + TW'(1);
            state_r     <= ST_WR_WAIT;
          end else if (tmo_hit_s) begin
            mwr_valid_r     <= 1'b0;
            rsp_status_r    <= RSP_TMO;
            rsp_data_r      <= '0;
            rsp_with_data_r <= 1'b0;
            load_r          <= 1'b1;
            state_r         <= ST_SEND;
          end else begin
            tmo_r <= tmo_r + TW'(1);
          end
        end
        ST_WR_WAIT: begin
          // the master's ready is still the pre-acceptance value in the first cycle
          if (!wr_first_r && mwr_ready) begin
            rsp_status_r    <= (err_r | mwr_error) ? RSP_ERR : RSP_OK;
            rsp_data_r      <= '0;
            rsp_with_data_r <= 1'b0;
            load_r          <= 1'b1;
            state_r         <= ST_SEND;
          end else if (tmo_hit_s) begin
            rsp_status_r    <= RSP_TMO;
            rsp_data_r      <= '0;
            rsp_with_data_r <= 1'b0;
            load_r          <= 1'b1;
            state_r         <= ST_SEND;
          end else begin
            err_r      <= err_r | mwr_error;
            wr_first_r <= 1'b0;
            tmo_r      <= tmo_r + TW'(1);
          end
        end
        ST_RD_REQ: begin
          if (mrd_addr_ready) begin
            mrd_addr_valid_r <= 1'b0;
            mrd_data_ready_r <= 1'b1;
            err_r            <= 1'b0;
            tmo_r            <= tmo_r + TW'(1);
            state_r          <= ST_RD_WAIT;
          end else if (tmo_hit_s) begin
            mrd_addr_valid_r <= 1'b0;
            rsp_status_r     <= RSP_TMO;
            rsp_data_r       <= '0;
            rsp_with_data_r  <= 1'b1;
            load_r           <= 1'b1;
            state_r          <= ST_SEND;
          end else begin
            tmo_r <= tmo_r + TW'(1);
          end
        end
        ST_RD_WAIT: begin
          if (mrd_data_valid) begin
            mrd_data_ready_r <= 1'b0;
            rsp_status_r     <= (err_r | mrd_error) ? RSP_ERR : RSP_OK;
            rsp_data_r       <= (err_r | mrd_error) ? '0 : mrd_data;
            rsp_with_data_r  <= 1'b1;
            load_r           <= 1'b1;
            state_r          <= ST_SEND;
          end else if (tmo_hit_s) begin
            mrd_data_ready_r <= 1'b0;
            rsp_status_r     <= RSP_TMO;
            rsp_data_r       <= '0;
            rsp_with_data_r  <= 1'b1;
            load_r           <= 1'b1;
            state_r          <= ST_SEND;
          end else begin
            err_r <= err_r | mrd_error;
            tmo_r <= tmo_r + TW'(1);
          end
        end
        ST_SEND: begin
          if (ser_done_s) begin
            rx_ready_r <= 1'b1;
            state_r    <= ST_IDLE;
          end
        end
        default: begin
          rx_ready_r       <= 1'b1;
          mwr_valid_r      <= 1'b0;
          mrd_addr_valid_r <= 1'b0;
          mrd_data_ready_r <= 1'b0;
          state_r          <= ST_IDLE;
        end
      endcase
    end
  end

  byte_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (load_r),
    .status   (rsp_status_r),
    .data     (rsp_data_r),
    .with_data(rsp_with_data_r),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .done     (ser_done_s)
  );

endmodule

// File: doc/uart_axi_cmd_parser.md
Name: uart_axi_cmd_parser

Overview:
- Byte-stream command decoder between the UART byte interface (rx/tx) and the AXI-lite master's custom mwr/mrd ports.
- Assembles write/read commands from received bytes and issues them on mwr/mrd.
- Waits for completion, then returns a status byte, plus data bytes for reads, on the tx byte stream.
- Gives a host PC register access over a serial link.

Parameters:
- ADDR_WIDTH, 32, address width in bits; multiple of 8.
- DATA_WIDTH, 32, data width in bits; multiple of 8.
- TIMEOUT_CYCLES, 1000000, idle clocks allowed between rx bytes, or while waiting for a master response, before abort.

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous reset, active-high
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  parser accepts byte (valid&ready = consumed)
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid; held until tx_ready
- tx_ready  in  1  transmitter accepts byte
- mwr_valid  out  1  write request
- mwr_addr  out  ADDR_WIDTH  write address
- mwr_data  out  DATA_WIDTH  write data
- mwr_ready  in  1  master idle/accepting
- mwr_error  in  1  1-cycle pulse: write response SLVERR/DECERR
- mrd_addr_valid  out  1  read request
- mrd_addr  out  ADDR_WIDTH  read address
- mrd_addr_ready  in  1  master accepting read
- mrd_data  in  DATA_WIDTH  read data
- mrd_data_valid  in  1  read data valid
- mrd_data_ready  out  1  parser accepts read data
- mrd_error  in  1  1-cycle pulse: read response error

Behaviour:
- Reset: all outputs 0 except rx_ready=1; state IDLE; counters 0; addr/data regs 0.
- Protocol:
  - 'W' (0x57), then ADDR_WIDTH/8 address bytes, then DATA_WIDTH/8 data bytes, all MSB first.
  - 'R' (0x52), then ADDR_WIDTH/8 address bytes.
  - Responses: 'K' (0x4B) ok, 'E' (0x45) bus error, 'T' (0x54) master timeout, '?' (0x3F) unknown command. A read returns the status byte followed by DATA_WIDTH/8 data bytes MSB first (data bytes sent as 0 on 'E' or 'T').
- States:
  - IDLE: rx_ready=1. 'W' or 'R' -> GET_ADDR; any other byte -> SEND with '?'.
  - GET_ADDR: shift bytes into addr reg. After the last byte: W -> GET_DATA, R -> RD_REQ.
  - GET_DATA: shift bytes into data reg. After the last byte -> WR_REQ.
  - WR_REQ: rx_ready=0; mwr_valid=1 held until mwr_valid&mwr_ready, then -> WR_WAIT.
  - WR_WAIT: ignore mwr_ready during the first cycle after acceptance. Afterwards mwr_ready=1 means done -> SEND; sticky error flag set by any mwr_error pulse seen in WR_REQ handshake cycle or WR_WAIT.
  - RD_REQ: mrd_addr_valid=1 until mrd_addr_valid&mrd_addr_ready -> RD_WAIT.
  - RD_WAIT: mrd_data_ready=1. On mrd_data_valid, capture mrd_data and error (mrd_error seen in RD_WAIT) -> SEND.
  - SEND: serialize the response from a shift register; next byte presented the cycle after each tx handshake. After the last byte -> IDLE.
- rx_ready=1 only in IDLE/GET_ADDR/GET_DATA; bytes are never dropped while rx_ready=1.
- Inter-byte timeout: in GET_ADDR/GET_DATA, the counter resets on each accepted byte and increments otherwise. At TIMEOUT_CYCLES -> IDLE silently, partial command discarded, no bus access.
- Response timeout: in WR_REQ/WR_WAIT/RD_REQ/RD_WAIT, reaching TIMEOUT_CYCLES -> drop mwr_valid/mrd_addr_valid, SEND 'T'.
- mwr_addr/mwr_data/mrd_addr remain stable while the corresponding valid is high.
- rst mid-operation: immediate return to reset state next cycle; pending tx byte abandoned.
- Throughput: one byte per cycle on rx and tx when the partner is ready.

Decomposition:
- Shared package uart_axi_pkg: command/response byte constants (CMD_WR, CMD_RD, RSP_OK, RSP_ERR, RSP_TMO, RSP_UNK) and the state enum encoding.
- One natural sub-module: byte_serializer (load N-byte word + status byte, emit MSB first over valid/ready); reused by the tx path.

Test Plan:
- rx 57 00 00 00 10 DE AD BE EF, master accepts, no error -> mwr_addr=0x00000010, mwr_data=0xDEADBEEF, single mwr_valid handshake, tx 4B.
- rx 52 00 00 00 20, master returns mrd_data=0x12345678 -> mrd_addr=0x00000020, tx 4B 12 34 56 78.
- Read with mrd_error pulse coincident with mrd_data_valid, data 0xFFFFFFFF -> tx 45 00 00 00 00.
- rx 57 00 00 then silence for TIMEOUT_CYCLES -> no mwr_valid, no tx; next command 52 00 00 00 04 processed normally.
- rx 0x41 -> tx 3F; mrd_addr_ready held 0 for TIMEOUT_CYCLES after 'R' command -> tx 54 00 00 00 00, mrd_addr_valid deasserted.
- tx_ready held low 50 cycles during read response -> tx_valid/tx_data stable, byte order 4B 12 34 56 78 preserved; rst asserted mid-SEND -> all outputs at reset values next cycle.
